// File: rtl/layer1_pkg.sv
// Shared constants, FSM state type and lane helper for the layer-1 column sequencer.
package layer1_pkg;

  localparam int L1_LANES  = 10;
  localparam int L1_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Extract lane i from a packed column word.
  function automatic logic [L1_DATA_W-1:0] lane_of(
    input logic [L1_LANES*L1_DATA_W-1:0] v,
    input int unsigned                   i
  );
    return v[i*L1_DATA_W +: L1_DATA_W];
  endfunction

endpackage

// File: rtl/layer1_tap_counter.sv
// Load/enable up-counter; tc flags that the count equals the supplied last value.
module layer1_tap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == last);

endmodule

// File: rtl/layer1_sequencer.sv
// Streams TAPS weight/pixel addresses into the layer-1 MAC column array and captures the result.
// Optional build macro: LAYER1_SEQ_RELU_EN clamps negative lanes to zero at capture.
module layer1_sequencer
  import layer1_pkg::*;
#(
  parameter int TAPS    = 25,
  parameter int ADDR_W  = 10,
  parameter int LANES   = L1_LANES,
  parameter int DATA_W  = L1_DATA_W,
  parameter int SKEW    = 1,
  parameter int MAC_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    start_ready,
  input  logic [ADDR_W-1:0]       wt_base,
  input  logic [ADDR_W-1:0]       px_base,
  output logic                    wt_rd,
  output logic [ADDR_W-1:0]       wt_addr,
  output logic                    px_rd,
  output logic [ADDR_W-1:0]       px_addr,
  output logic                    acc_clr,
  input  logic [LANES*DATA_W-1:0] column,
  output logic [LANES*DATA_W-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output state_e                  dbg_state
);

  // Handshakes: a job transfers when start && start_ready, a result when res_valid && res_ready;
  // valid holds with stable data until it transfers, and ready never depends on valid.

  localparam int DRAIN_W = $clog2(SKEW + MAC_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0]  TAP_LAST   = ADDR_W'(TAPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SKEW + MAC_LAT);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       wt_base_q, wt_base_d;
  logic [ADDR_W-1:0]       px_base_q, px_base_d;
  logic [LANES*DATA_W-1:0] res_q, res_d;

  logic                    tap_load, tap_en, tap_tc;
  logic [ADDR_W-1:0]       tap_k;
  logic                    dr_load, dr_en, dr_tc;
  logic [DRAIN_W-1:0]      dr_cnt;
  logic                    capture;
  logic                    issue;

  // Stage SKEW-1 feeds the pixel memory; stage SKEW marks the tap sitting at the array inputs.
  logic [SKEW:0]           dl_rd_q, dl_rd_d;
  logic [SKEW:0]           dl_first_q, dl_first_d;
  logic [ADDR_W-1:0]       dl_k_q [SKEW];
  logic [ADDR_W-1:0]       dl_k_d [SKEW];

  layer1_tap_counter #(.W(ADDR_W)) u_tap_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tap_load),
    .load_val ('0),
    .en       (tap_en),
    .last     (TAP_LAST),
    .count    (tap_k),
    .tc       (tap_tc)
  );

  layer1_tap_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (dr_load),
    .load_val ('0),
    .en       (dr_en),
    .last     (DRAIN_LAST),
    .count    (dr_cnt),
    .tc       (dr_tc)
  );

  always_comb begin
    state_d     = state_q;
    wt_base_d   = wt_base_q;
    px_base_d   = px_base_q;
    tap_load    = 1'b0;
    tap_en      = 1'b0;
    dr_load     = 1'b0;
    dr_en       = 1'b0;
    capture     = 1'b0;
    start_ready = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start) begin
          wt_base_d = wt_base;
          px_base_d = px_base;
          tap_load  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tap_en = 1'b1;
        if (tap_tc) begin
          dr_load = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        dr_en = 1'b1;
        if (dr_tc) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue = (state_q == ISSUE);

  always_comb begin
    dl_rd_d       = dl_rd_q;
    dl_first_d    = dl_first_q;
    dl_k_d        = dl_k_q;
    dl_rd_d[0]    = issue;
    dl_first_d[0] = issue && (tap_k == '0);
    dl_k_d[0]     = issue ? tap_k : '0;
    for (int i = 1; i <= SKEW; i++) begin
      dl_rd_d[i]    = dl_rd_q[i-1];
      dl_first_d[i] = dl_first_q[i-1];
    end
    for (int i = 1; i < SKEW; i++) begin
      dl_k_d[i] = dl_k_q[i-1];
    end
  end

  always_comb begin
    res_d = res_q;
    if (capture) begin
      for (int i = 0; i < LANES; i++) begin
`ifdef LAYER1_SEQ_RELU_EN
        res_d[i*DATA_W +: DATA_W] = column[i*DATA_W + DATA_W - 1] ? '0 : column[i*DATA_W +: DATA_W];
`else
        res_d[i*DATA_W +: DATA_W] = column[i*DATA_W +: DATA_W];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wt_base_q  <= '0;
      px_base_q  <= '0;
      res_q      <= '0;
      dl_rd_q    <= '0;
      dl_first_q <= '0;
      for (int i = 0; i < SKEW; i++) begin
        dl_k_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wt_base_q  <= wt_base_d;
      px_base_q  <= px_base_d;
      res_q      <= res_d;
      dl_rd_q    <= dl_rd_d;
      dl_first_q <= dl_first_d;
      dl_k_q     <= dl_k_d;
    end
  end

  assign wt_rd     = issue;
  assign wt_addr   = issue ? (wt_base_q + tap_k) : '0;
  assign px_rd     = dl_rd_q[SKEW-1];
  assign px_addr   = px_rd ? (px_base_q + dl_k_q[SKEW-1]) : '0;
  // Clear stays high except while taps 1..TAPS-1 are at the array, so tap 0 overwrites stale sums.
  assign acc_clr   = !(dl_rd_q[SKEW] && !dl_first_q[SKEW]);
  assign res_data  = res_q;
  assign res_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_layer1_sequencer.sv
// Directed bench for layer1_sequencer with a behavioural MAC array and memories.
module tb_layer1_sequencer;
  import layer1_pkg::*;

  localparam int TAPS   = 25;
  localparam int ADDR_W = 10;
  localparam int LANES  = 10;
  localparam int DATA_W = 16;
  localparam int W      = LANES * DATA_W;

`ifdef LAYER1_SEQ_RELU_EN
  localparam logic [15:0] NEG_LANE = 16'h0000;
`else
  localparam logic [15:0] NEG_LANE = 16'hFFF6;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              start_ready;
  logic [ADDR_W-1:0] wt_base, px_base;
  logic              wt_rd, px_rd, acc_clr;
  logic [ADDR_W-1:0] wt_addr, px_addr;
  logic [W-1:0]      column, res_data;
  logic              res_valid, res_ready, busy;
  state_e            dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  layer1_sequencer dut (
    .clk(clk), .reset(rst_n), .start(start), .start_ready(start_ready),
    .wt_base(wt_base), .px_base(px_base), .wt_rd(wt_rd), .wt_addr(wt_addr),
    .px_rd(px_rd), .px_addr(px_addr), .acc_clr(acc_clr), .column(column),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- memories and MAC array model (sync-read memories, registered weight)
  logic [DATA_W-1:0] wmem [1024];
  logic [W-1:0]      pmem [1024];
  logic [DATA_W-1:0] wt_q, wt_r;
  logic [W-1:0]      px_q;
  logic [DATA_W-1:0] acc [LANES];

  always @(posedge clk) begin
    if (wt_rd) wt_q <= wmem[wt_addr];
    wt_r <= wt_q;
    if (px_rd) px_q <= pmem[px_addr];
    for (int j = 0; j < LANES; j++) begin
      logic [DATA_W-1:0] prod;
      prod = DATA_W'(wt_r * px_q[j*DATA_W +: DATA_W]);
      acc[j] <= acc_clr ? prod : DATA_W'(acc[j] + prod);
    end
  end

  always_comb begin
    column = '0;
    for (int j = 0; j < LANES; j++) column[j*DATA_W +: DATA_W] = acc[j];
  end

  // ---------------- scoreboard
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_result(input logic [15:0] other, input logic [15:0] l3);
    for (int j = 0; j < LANES; j++) begin
      chk($sformatf("res_lane%0d", j), W'(lane_of(res_data, j)), W'((j == 3) ? l3 : other));
    end
  endtask

  // ---------------- driver tasks
  task automatic start_job(input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] pb);
    chk("start_ready_idle", W'(start_ready), W'(1));
    start = 1'b1; wt_base = wb; px_base = pb;
    @(negedge clk);
    start = 1'b0; wt_base = '0; px_base = '0;
  endtask

  // Called in cycle 0; traces every issue/drain cycle and returns at the first HOLD cycle.
  task automatic trace_job(input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] pb);
    int lat;
    logic e_wrd, e_prd, e_clr;
    lat = -1;
    for (int c = 0; c < 60; c++) begin
      if (res_valid) begin
        lat = c;
        break;
      end
      e_wrd = (c < TAPS);
      e_prd = (c >= 1) && (c <= TAPS);
      e_clr = !((c >= 3) && (c <= TAPS + 1));
      chk("wt_rd", W'(wt_rd), W'(e_wrd));
      chk("wt_addr", W'(wt_addr), e_wrd ? W'(ADDR_W'(wb + c)) : W'(0));
      chk("px_rd", W'(px_rd), W'(e_prd));
      chk("px_addr", W'(px_addr), e_prd ? W'(ADDR_W'(pb + c - 1)) : W'(0));
      chk("acc_clr", W'(acc_clr), W'(e_clr));
      chk("busy", W'(busy), W'(1));
      @(negedge clk);
    end
    chk("res_valid_cycle", W'(lat), W'(28));
  endtask

  // Holds the result for stall cycles (with a competing start), then hands it off.
  task automatic finish_job(input int stall, input logic [15:0] other, input logic [15:0] l3);
    chk_result(other, l3);
    for (int s = 0; s < stall; s++) begin
      res_ready = 1'b0;
      start = 1'b1; wt_base = ADDR_W'($urandom_range(0, 1023)); px_base = ADDR_W'($urandom_range(0, 1023));
      chk("hold_valid", W'(res_valid), W'(1));
      chk("hold_busy", W'(busy), W'(1));
      chk("hold_start_ready", W'(start_ready), W'(0));
      chk_result(other, l3);
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_hs_valid", W'(res_valid), W'(0));
    chk("after_hs_busy", W'(busy), W'(0));
  endtask

  typedef struct {
    logic [ADDR_W-1:0] wb;
    logic [ADDR_W-1:0] pb;
    logic              pre_ready;
    int                stall;
    logic [15:0]       exp_other;
    logic [15:0]       exp_l3;
  } vec_t;

  vec_t vecs [3];
  int   valid_seen;

  initial begin
    // Weights 1 except 2 at 0x3F0..0x3FF and 3 at 0x000..0x008.
    // Pixels 2 per lane except 0x100..0x118: lanes 1, lane 3 = -2 for the first five then 0.
    for (int a = 0; a < 1024; a++) begin
      wmem[a] = 16'd1;
      if (a >= 'h3F0) wmem[a] = 16'd2;
      if (a <= 'h008) wmem[a] = 16'd3;
      for (int j = 0; j < LANES; j++) begin
        pmem[a][j*DATA_W +: DATA_W] = 16'd2;
        if (a >= 'h100 && a <= 'h118) begin
          pmem[a][j*DATA_W +: DATA_W] = 16'd1;
          if (j == 3) pmem[a][j*DATA_W +: DATA_W] = (a < 'h105) ? 16'hFFFE : 16'h0000;
        end
      end
    end
    wt_q = '0; wt_r = '0; px_q = '0;

    vecs[0] = '{wb: 10'h010, pb: 10'h200, pre_ready: 1'b0, stall: 0,  exp_other: 16'h0032, exp_l3: 16'h0032};
    vecs[1] = '{wb: 10'h3F0, pb: 10'h200, pre_ready: 1'b1, stall: 0,  exp_other: 16'h0076, exp_l3: 16'h0076};
    vecs[2] = '{wb: 10'h010, pb: 10'h100, pre_ready: 1'b0, stall: 10, exp_other: 16'h0019, exp_l3: NEG_LANE};

    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; wt_base = '0; px_base = '0;
    #1;
    chk("rst_wt_rd", W'(wt_rd), W'(0));
    chk("rst_px_rd", W'(px_rd), W'(0));
    chk("rst_acc_clr", W'(acc_clr), W'(1));
    chk("rst_res_valid", W'(res_valid), W'(0));
    chk("rst_res_data", res_data, '0);
    chk("rst_busy", W'(busy), W'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      res_ready = vecs[v].pre_ready;
      start_job(vecs[v].wb, vecs[v].pb);
      trace_job(vecs[v].wb, vecs[v].pb);
      finish_job(vecs[v].stall, vecs[v].exp_other, vecs[v].exp_l3);
    end

    // Reset in cycle 12 of ISSUE discards the job.
    start_job(10'h010, 10'h200);
    repeat (12) @(negedge clk);
    chk("pre_rst_wt_addr", W'(wt_addr), W'(10'h01C));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wt_rd", W'(wt_rd), W'(0));
    chk("mid_rst_wt_addr", W'(wt_addr), W'(0));
    chk("mid_rst_px_rd", W'(px_rd), W'(0));
    chk("mid_rst_px_addr", W'(px_addr), W'(0));
    chk("mid_rst_acc_clr", W'(acc_clr), W'(1));
    chk("mid_rst_res_data", res_data, '0);
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_start_ready", W'(start_ready), W'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid) valid_seen++;
    end
    chk("no_valid_after_rst", W'(valid_seen), W'(0));
    chk("idle_after_rst", W'(busy), W'(0));

    start_job(10'h010, 10'h200);
    trace_job(10'h010, 10'h200);
    finish_job(0, 16'h0032, 16'h0032);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer1_sequencer.md
# layer1_sequencer

Controller that runs one output column group through the layer-1 MAC column array (10 lanes × 16-bit, shared broadcast weight, active-high accumulator clear). For each accepted job it streams TAPS weight and pixel-vector addresses to the weight and pixel memories. It aligns the accumulator clear with the first product and waits out the pipeline. It then captures the finished column into a result register offered downstream on a valid/ready handshake. It sits between the layer-1 top-level scheduler (job source) and the MAC array plus its two read-only memories.

## Interface
Parameters:
- TAPS, 25, kernel taps (MAC operations) per job; legal range 1..2^ADDR_W
- ADDR_W, 10, weight and pixel memory address width
- LANES, 10, MAC lanes in the array
- DATA_W, 16, per-lane data width, two's complement
- SKEW, 1, cycles pixel address lags weight address (covers the array's internal weight register)
- MAC_LAT, 1, cycles from operands at array input to updated column output

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  job request
- start_ready  out  1  high in IDLE; job accepted when start && start_ready
- wt_base  in  ADDR_W  first weight address, sampled on accept
- px_base  in  ADDR_W  first pixel-vector address, sampled on accept
- wt_rd  out  1  weight memory read strobe
- wt_addr  out  ADDR_W  weight memory address
- px_rd  out  1  pixel memory read strobe
- px_addr  out  ADDR_W  pixel memory address
- acc_clr  out  1  drives the array's accumulator clear (active-high)
- column  in  LANES*DATA_W  array accumulator outputs
- res_data  out  LANES*DATA_W  captured result, lane i at [i*DATA_W +: DATA_W]
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE → ISSUE → DRAIN → HOLD → IDLE.
- IDLE:
  - start_ready=1, acc_clr=1, strobes 0.
  - On accept, latch the bases and go to ISSUE.
- ISSUE, TAPS cycles, tap counter k=0..TAPS-1:
  - wt_rd=1, wt_addr=wt_base+k.
  - Pixel stream is the same sequence delayed SKEW cycles: px_rd=1, px_addr=px_base+k. A delay line continues into DRAIN.
  - Addresses wrap modulo 2^ADDR_W.
- DRAIN:
  - Lasts SKEW+MAC_LAT+1 cycles.
  - On its last cycle, capture column into res_data; next state HOLD.
- HOLD:
  - res_valid=1 and res_data stable until res_ready.
  - On res_valid && res_ready, go to IDLE.
- acc_clr rule:
  - acc_clr=0 exactly in the cycles in which taps 1..TAPS-1 sit at the array inputs.
  - acc_clr=1 in every other cycle, including the cycle of tap 0, so the tap-0 product replaces stale contents.
- Reset, asynchronous at any time including mid-job:
  - State IDLE, counters 0, all strobes 0, acc_clr=1, res_valid=0, res_data=0, addresses 0.
  - A partial job is discarded.
- start while busy is ignored; there is no queueing.

## Timing
- Cycle 0 is the first ISSUE cycle; the cycle after accept is cycle 0.
- Tap k weight address in cycle k; pixel address in cycle k+SKEW; tap k operands at the array in cycle k+SKEW+1.
- acc_clr=1 in cycle SKEW+1; acc_clr=0 in cycles SKEW+2..TAPS+SKEW.
- The final column is valid in cycle TAPS+SKEW+MAC_LAT. It is captured at the end of that cycle.
- res_valid rises in cycle TAPS+SKEW+MAC_LAT+1: 28 at defaults.
- TAPS=1: acc_clr is never deasserted during the job.
- A handshake in HOLD returns to IDLE next cycle; a start in that IDLE cycle is accepted. Minimum job-to-job spacing is TAPS+SKEW+MAC_LAT+3 cycles.
- res_ready high before res_valid has no effect.

## Configuration
- LAYER1_SEQ_RELU_EN defined:
  - At capture, each lane whose sign bit is 1 is stored as 0; non-negative lanes pass unchanged.
  - Adds no latency.
- LAYER1_SEQ_RELU_EN undefined: res_data is the raw column.

## Structure
- layer1_pkg:
  - LANES and DATA_W constants.
  - State enum type (IDLE, ISSUE, DRAIN, HOLD).
  - Lane-slice helper function.
- One sub-module, layer1_tap_counter:
  - Load/enable counter with terminal-count flag.
  - Instantiated twice: ISSUE tap counter and DRAIN counter.
- SKEW delay line: inline shift register of {rd, addr}.

## Test plan
- Reset then single job, wt_base=0x010, px_base=0x200, defaults:
  - wt_addr 0x010..0x028 in cycles 0..24; px_addr 0x200..0x218 in cycles 1..25.
  - acc_clr=1 in cycle 2 and 0 in cycles 3..26; res_valid in cycle 28.
- Model MAC array with all weights=1 and pixels=2 per lane: res_data every lane = 50 (0x0032).
- Backpressure: res_ready low for 10 cycles:
  - res_data and res_valid stay stable, busy=1, start ignored.
  - Handshake, then start in the next cycle is accepted.
- wt_base=0x3F0, TAPS=25: wt_addr wraps 0x3FF→0x000; result matches model.
- Reset asserted in cycle 12 of ISSUE:
  - All outputs take reset values immediately; res_valid never rises.
  - A new job after release produces a correct result.
- With LAYER1_SEQ_RELU_EN and a lane summing to 0xFFF6 (−10): that lane reads 0, others unchanged; without the macro it reads 0xFFF6.
